// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: req/addr out from the fetch unit, ack/rdata/err back.
// mem_rdata and mem_err are only meaningful in a cycle where mem_ack is high.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: one req/ack read per fetch_start, with halt-word
// substitution and a sticky fault code on misalignment, bus error or timeout.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [31:0] HALT_INSTR  = 32'hFC00_0000,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        mem,
    input  logic                      fetch_start_i,
    input  logic [31:0]               pc_i,
    input  logic                      fault_clr_i,
    output logic [31:0]               instr_out_o,
    output logic [31:0]               fetch_pc_o,
    output logic                      instr_valid_o,
    output logic                      busy_o,
    output logic                      fetch_fault_o,
    output logic [1:0]                fault_code_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_BUSERR   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    // Last REQ cycle index; the edge ending that cycle fires the timeout.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [31:0] instr_q;
    logic [31:0] fetch_pc_q;
    logic        valid_q;
    logic        fault_q;
    logic [1:0]  code_q;

    logic        pc_aligned;
    logic        timeout_hit;

    assign pc_aligned  = (pc_i[1:0] == 2'b00);
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign cnt_d       = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            cnt_q      <= 8'd0;
            instr_q    <= RESET_INSTR;
            fetch_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= CODE_NONE;
        end else begin
            valid_q <= 1'b0;

            // A fault raised at this same edge overrides the clear below.
            if (fault_clr_i) begin
                fault_q <= 1'b0;
                code_q  <= CODE_NONE;
            end

            case (state_q)
                IDLE: begin
                    if (fetch_start_i) begin
                        if (pc_aligned) begin
                            mem_addr_q <= pc_i;
                            mem_req_q  <= 1'b1;
                            cnt_q      <= 8'd0;
                            state_q    <= REQ;
                        end else begin
                            instr_q    <= HALT_INSTR;
                            fetch_pc_q <= pc_i;
                            valid_q    <= 1'b1;
                            fault_q    <= 1'b1;
                            code_q     <= CODE_MISALIGN;
                        end
                    end
                end

                REQ: begin
                    // An ack coinciding with the timeout edge counts as a normal completion.
                    if (mem.mem_ack) begin
                        instr_q    <= mem.mem_err ? HALT_INSTR : mem.mem_rdata;
                        fetch_pc_q <= mem_addr_q;
                        valid_q    <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                        if (mem.mem_err) begin
                            fault_q <= 1'b1;
                            code_q  <= CODE_BUSERR;
                        end
                    end else if (timeout_hit) begin
                        instr_q    <= HALT_INSTR;
                        fetch_pc_q <= mem_addr_q;
                        valid_q    <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                        fault_q    <= 1'b1;
                        code_q     <= CODE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = mem_addr_q;
    assign instr_out_o   = instr_q;
    assign fetch_pc_o    = fetch_pc_q;
    assign instr_valid_o = valid_q;
    assign busy_o        = (state_q == REQ);
    assign fetch_fault_o = fault_q;
    assign fault_code_o  = code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized fetch transactions, checked against a transaction-level
// model of the fetch rules (outcome, latency, request length, sticky fault).
module tb_instr_fetch_unit;

    localparam int          TO   = 4;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        fault_clr = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] fetch_pc;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;
    logic [1:0]  fault_code;

    instr_fetch_unit_if mem_if ();

    instr_fetch_unit #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (mem_if),
        .fetch_start_i (fetch_start),
        .pc_i          (pc),
        .fault_clr_i   (fault_clr),
        .instr_out_o   (instr_out),
        .fetch_pc_o    (fetch_pc),
        .instr_valid_o (instr_valid),
        .busy_o        (busy),
        .fetch_fault_o (fetch_fault),
        .fault_code_o  (fault_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what the unit should currently be presenting.
    logic [31:0] exp_instr = 32'h0;
    logic [31:0] exp_pc    = 32'h0;
    logic        exp_fault = 1'b0;
    logic [1:0]  exp_code  = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_instr"}, instr_out, exp_instr);
        check({tag, "_pc"}, fetch_pc, exp_pc);
        check({tag, "_fault"}, {31'h0, fetch_fault}, {31'h0, exp_fault});
        check({tag, "_code"}, {30'h0, fault_code}, {30'h0, exp_code});
    endtask

    // One fetch. d = ack delay in REQ cycles (0 = ack in first REQ cycle); d >= TO means no ack.
    // hold keeps fetch_start high with a different pc during REQ; clr pulses fault_clr on the
    // edge that completes the fetch.
    task automatic do_fetch(input logic [31:0] addr, input int d, input logic err,
                            input logic [31:0] rdata, input bit hold, input bit clr);
        bit          aligned;
        bit          acked;
        bit          seen;
        bit          new_fault;
        int          lat;
        int          req_cycles;
        int          exp_lat;
        int          exp_req;
        int          end_c;
        logic [1:0]  new_code;
        logic [31:0] new_instr;

        aligned = (addr[1:0] == 2'b00);
        acked   = aligned && (d < TO);
        if (!aligned) begin
            new_fault = 1'b1; new_code = 2'b01; new_instr = HALT;
            exp_req = 0; exp_lat = 1;
        end else if (acked) begin
            new_fault = err; new_code = 2'b10; new_instr = err ? HALT : rdata;
            exp_req = d + 1; exp_lat = d + 2;
        end else begin
            new_fault = 1'b1; new_code = 2'b11; new_instr = HALT;
            exp_req = TO; exp_lat = TO + 1;
        end
        end_c = acked ? d : TO - 1;

        fetch_start = 1'b1;
        pc          = addr;
        fault_clr   = clr && !aligned;
        step();
        fetch_start = hold;
        if (hold) pc = addr ^ 32'h0000_00CC;
        seen = 1'b0; lat = 0; req_cycles = 0;
        for (int c = 0; c < TO + 8; c++) begin
            mem_if.mem_ack = 1'b0;
            mem_if.mem_err = 1'b0;
            fault_clr      = 1'b0;
            if (instr_valid) begin
                seen = 1'b1;
                lat  = c + 1;
                break;
            end
            if (mem_if.mem_req) begin
                req_cycles++;
                check("mem_addr", mem_if.mem_addr, addr);
            end
            if (acked && c == d) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = rdata;
                mem_if.mem_err   = err;
            end
            if (aligned && clr && c == end_c) fault_clr = 1'b1;
            step();
        end
        fetch_start    = 1'b0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_err = 1'b0;
        fault_clr      = 1'b0;

        if (new_fault) begin
            exp_fault = 1'b1;
            exp_code  = new_code;
        end else if (clr) begin
            exp_fault = 1'b0;
            exp_code  = 2'b00;
        end
        exp_instr = new_instr;
        exp_pc    = addr;

        check("valid_seen", {31'h0, seen}, 32'h1);
        check("latency", lat, exp_lat);
        check("req_cycles", req_cycles, exp_req);
        check("busy_done", {31'h0, busy}, 32'h0);
        check_state("done");
        step();
        check("valid_pulse", {31'h0, instr_valid}, 32'h0);
        check("req_after", {31'h0, mem_if.mem_req}, 32'h0);
        $display("txn pc=%h delay=%0d err=%0b hold=%0b clr=%0b instr=%h code=%0d lat=%0d",
                 addr, d, err, hold, clr, instr_out, fault_code, lat);
    endtask

    // Idle cycles with stray acks and occasional fault_clr; nothing may change except the clear.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_if.mem_ack   = 1'($urandom_range(0, 1));
            mem_if.mem_rdata = $urandom;
            mem_if.mem_err   = 1'($urandom_range(0, 1));
            fault_clr        = ($urandom_range(0, 3) == 0);
            step();
            if (fault_clr) begin
                exp_fault = 1'b0;
                exp_code  = 2'b00;
            end
            mem_if.mem_ack = 1'b0;
            mem_if.mem_err = 1'b0;
            fault_clr      = 1'b0;
            check("idle_valid", {31'h0, instr_valid}, 32'h0);
            check("idle_req", {31'h0, mem_if.mem_req}, 32'h0);
            check_state("idle");
        end
    endtask

    logic [31:0] r_pc;
    logic [31:0] r_data;
    int          r_d;

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        mem_if.mem_err   = 1'b0;

        // Reset held with mem_ack toggling.
        for (int i = 0; i < 4; i++) begin
            mem_if.mem_ack   = ~mem_if.mem_ack;
            mem_if.mem_rdata = $urandom;
            step();
            check("rst_req", {31'h0, mem_if.mem_req}, 32'h0);
            check("rst_addr", mem_if.mem_addr, 32'h0);
            check("rst_valid", {31'h0, instr_valid}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
            check_state("rst");
        end
        mem_if.mem_ack = 1'b0;
        rst_n = 1'b1;
        step();
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'h1234_5678;
        step();
        mem_if.mem_ack = 1'b0;
        check("stray_valid", {31'h0, instr_valid}, 32'h0);
        check_state("stray");

        // Zero-wait fetch, then a 3-cycle wait with fetch_start held and pc moved.
        do_fetch(32'h40, 0, 1'b0, 32'h8C22_0004, 1'b0, 1'b0);
        do_fetch(32'h44, 3, 1'b0, 32'hAC43_0008, 1'b1, 1'b0);
        // Misaligned, bus error, then timeout with fault_clr on the timeout edge.
        do_fetch(32'h42, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_fetch(32'h48, 1, 1'b1, 32'h0123_4567, 1'b0, 1'b0);
        do_fetch(32'h4C, TO + 2, 1'b0, 32'h0, 1'b0, 1'b1);
        // Ack on the timeout edge completes normally, and fault_clr there clears the flag.
        do_fetch(32'h50, TO - 1, 1'b0, 32'h2108_0001, 1'b0, 1'b1);

        // Asynchronous reset during REQ.
        fetch_start = 1'b1;
        pc          = 32'h60;
        step();
        fetch_start = 1'b0;
        step();
        check("mid_req", {31'h0, mem_if.mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {31'h0, mem_if.mem_req}, 32'h0);
        check("async_busy", {31'h0, busy}, 32'h0);
        exp_instr = 32'h0; exp_pc = 32'h0; exp_fault = 1'b0; exp_code = 2'b00;
        check_state("async");
        step();
        rst_n            = 1'b1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_if.mem_ack = 1'b0;
        check("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        check("late_ack_req", {31'h0, mem_if.mem_req}, 32'h0);
        check_state("late_ack");
        do_fetch(32'h64, 2, 1'b0, 32'h0042_0020, 1'b0, 1'b0);

        // Randomized fetches.
        for (int t = 0; t < 150; t++) begin
            r_pc = $urandom;
            if ($urandom_range(0, 5) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
            else                           r_pc[1:0] = 2'b00;
            r_d    = $urandom_range(0, TO + 1);
            r_data = $urandom;
            do_fetch(r_pc, r_d, ($urandom_range(0, 3) == 0), r_data,
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
